uart_cmd_deframer: RTL and testbench
====================================

// Module: uart_cmd_deframer
// PURPOSE
//  Consumer stage directly downstream of the CoreUART receive side.
//  Polls RXRDY and strobes CSN/OEN low to pop each received byte, then samples DATA_OUT and the line-error flags.
//  Assembles fixed 6-byte command frames and presents each decoded register read/write on a valid/ready port.
//  Feeds the test-firmware register bus.
// PARAMETERS
//  RD_LAT      2        cycles from OEN rising edge to DATA_OUT/error sample (1..3)
//  TIMEOUT_CYC 100000   max CLK cycles between bytes inside a frame before abort
//  SOF_BYTE    8'hA5    start-of-frame marker
// PORTS
//  CLK           in   1   system clock, rising edge
//  RESET         in   1   asynchronous, active-high reset
//  uart_rxrdy    in   1   UART receive data available
//  uart_data     in   8   UART DATA_OUT
//  uart_par_err  in   1   UART PARITY_ERR, sampled with data
//  uart_frm_err  in   1   UART FRAMING_ERR, sampled with data
//  uart_ovf      in   1   UART OVERFLOW level
//  uart_csn      out  1   UART chip select, active low
//  uart_oen      out  1   UART read strobe, active low
//  cmd_valid     out  1   decoded command available
//  cmd_ready     in   1   downstream accepts command
//  cmd_wr        out  1   1=write, 0=read (CMD[7])
//  cmd_addr      out  8   register address
//  cmd_wdata     out  16  write data {DATA_H,DATA_L}
//  err_chk       out  1   1-cycle pulse: checksum mismatch
//  err_timeout   out  1   1-cycle pulse: inter-byte timeout
//  err_line      out  1   1-cycle pulse: parity/framing error or overflow rising edge
//  err_cnt       out  8   saturating count of all error pulses
// BEHAVIOUR
//  Reset values:
//   - uart_csn=1, uart_oen=1, cmd_valid=0, cmd_wr=0, cmd_addr=0, cmd_wdata=0.
//   - All err_* outputs 0; FSMs in RD_IDLE/HUNT.
//  Reset is honoured mid-frame and mid-strobe: any partial frame is discarded.
//  Byte reader FSM: RD_IDLE -> RD_STRB -> RD_WAIT -> RD_IDLE.
//   - RD_IDLE: move to RD_STRB when uart_rxrdy=1 and the frame FSM is not in OUTPUT.
//   - RD_STRB: csn=0 and oen=0 for exactly 1 cycle.
//   - RD_WAIT: wait RD_LAT cycles, then sample data and error flags and issue internal byte_vld for 1 cycle.
//   - Max throughput: one byte per RD_LAT+2 cycles.
//  Frame format: SOF, CMD, ADDR, DH, DL, CHK, where CHK = CMD^ADDR^DH^DL.
//  Frame FSM: HUNT -> G_CMD -> G_ADDR -> G_DH -> G_DL -> G_CHK -> OUTPUT -> HUNT.
//   - HUNT: discard bytes != SOF_BYTE, with no error. SOF_BYTE advances to G_CMD.
//   - G_*: each byte_vld stores the byte and advances one state. A running XOR is cleared on SOF.
//   - G_CHK: on match, load cmd_* and go to OUTPUT with cmd_valid=1. On mismatch, err_chk pulse and go to HUNT.
//   - OUTPUT: cmd_* held stable while cmd_valid=1 and cmd_ready=0.
//   - OUTPUT: on cmd_valid & cmd_ready, cmd_valid=0 next cycle and go to HUNT.
//   - OUTPUT: no UART reads occur, so backpressure lands in the UART FIFO.
//  Line errors:
//   - A byte sampled with par_err or frm_err pulses err_line and aborts to HUNT. The byte is not a SOF candidate.
//   - A 0->1 edge on uart_ovf pulses err_line; the frame in progress aborts to HUNT.
//  Timeout:
//   - 17-bit counter, cleared on every byte_vld, runs only in G_CMD..G_CHK.
//   - Reaching TIMEOUT_CYC pulses err_timeout and goes to HUNT.
//   - The counter does not run in HUNT or OUTPUT.
//  Simultaneous events:
//   - Priority is line error > timeout > checksum.
//   - Only one err pulse fires per cycle, and err_cnt increments by 1.
//  err_cnt saturates at 8'hFF (no wrap).
// TESTING
//  T1:
//   - Stimulus: feed A5 81 10 12 34 B7, cmd_ready=1.
//   - Required: cmd_valid 1 cycle with cmd_wr=1, addr=10, wdata=1234; err_cnt=0.
//  T2:
//   - Stimulus: 3 garbage bytes 00 FF 5A, then A5 01 20 00 00 21.
//   - Required: read cmd addr=20; no errors.
//  T3:
//   - Stimulus: A5 81 10 12 34 B6.
//   - Required: err_chk pulse; no cmd_valid; err_cnt=1; next good frame decodes.
//  T4:
//   - Stimulus: hold cmd_ready=0 for 50 cycles with 2 frames queued in the UART FIFO.
//   - Required: cmd_* stable; oen stays 1; both frames emitted in order after ready=1.
//  T5:
//   - Stimulus: TIMEOUT_CYC=100; A5 81, then a 101-cycle gap.
//   - Required: err_timeout pulse; state HUNT; err_cnt=1.
//  T6:
//   - Stimulus: uart_par_err=1 on the ADDR byte; separately, RESET asserted during RD_WAIT.
//   - Required: parity case gives err_line and frame dropped.
//   - Required: reset case gives all outputs at reset values immediately (async), with no spurious cmd_valid after release.

Source files
------------

// File: rtl/uart_cmd_deframer.sv
// Pops bytes from a CoreUART receiver, assembles 6-byte SOF/CMD/ADDR/DH/DL/CHK
// frames and presents decoded register commands on a valid/ready port.
module uart_cmd_deframer #(
  parameter int          RD_LAT      = 2,
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [7:0]  SOF_BYTE    = 8'hA5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        uart_rxrdy,
  input  logic [7:0]  uart_data,
  input  logic        uart_par_err,
  input  logic        uart_frm_err,
  input  logic        uart_ovf,
  output logic        uart_csn,
  output logic        uart_oen,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_wr,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_wdata,
  output logic        err_chk,
  output logic        err_timeout,
  output logic        err_line,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {RD_IDLE, RD_STRB, RD_WAIT} rd_state_t;
  typedef enum logic [2:0] {F_HUNT, F_CMD, F_ADDR, F_DH, F_DL, F_CHK, F_OUTPUT} fr_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  rd_state_t   rd_q, rd_d;
  fr_state_t   fr_q, fr_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [16:0] tcnt_q, tcnt_d;
  logic        wrb_q, wrb_d;
  logic [7:0]  addr_q, addr_d, dh_q, dh_d, dl_q, dl_d, xor_q, xor_d;
  logic        cv_q, cv_d, cwr_q, cwr_d;
  logic [7:0]  caddr_q, caddr_d;
  logic [15:0] cwd_q, cwd_d;
  logic        ovf_q;
  logic        ech_q, eto_q, eln_q;
  logic [7:0]  ecnt_q;
  logic        byte_vld, in_frame, ovf_rise, line_ev, to_ev, chk_ev, good_byte;

  // Byte reader: the byte is consumed combinationally on the final wait cycle,
  // so the frame FSM has already left G_CHK before the reader can re-arm.
  always_comb begin
    rd_d     = rd_q;
    wcnt_d   = wcnt_q;
    byte_vld = 1'b0;
    case (rd_q)
      RD_IDLE: if (uart_rxrdy && fr_q != F_OUTPUT) rd_d = RD_STRB;
      RD_STRB: begin
        rd_d   = RD_WAIT;
        wcnt_d = 2'd0;
      end
      RD_WAIT: begin
        if (wcnt_q == 2'(RD_LAT - 1)) begin
          byte_vld = 1'b1;
          rd_d     = RD_IDLE;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  assign in_frame  = (fr_q == F_CMD) || (fr_q == F_ADDR) || (fr_q == F_DH) ||
                     (fr_q == F_DL) || (fr_q == F_CHK);
  assign ovf_rise  = uart_ovf & ~ovf_q;
  assign line_ev   = ovf_rise | (byte_vld & (uart_par_err | uart_frm_err));
  assign to_ev     = in_frame && (tcnt_q >= 17'(TIMEOUT_CYC));
  assign good_byte = byte_vld & ~(uart_par_err | uart_frm_err);

  always_comb begin
    fr_d    = fr_q;
    wrb_d   = wrb_q;
    addr_d  = addr_q;
    dh_d    = dh_q;
    dl_d    = dl_q;
    xor_d   = xor_q;
    cv_d    = cv_q;
    cwr_d   = cwr_q;
    caddr_d = caddr_q;
    cwd_d   = cwd_q;
    chk_ev  = 1'b0;
    tcnt_d  = (in_frame && !byte_vld) ? tcnt_q + 17'd1 : 17'd0;
    if (fr_q == F_OUTPUT) begin
      if (cmd_ready) begin
        cv_d = 1'b0;
        fr_d = F_HUNT;
      end
    end else if (in_frame && (line_ev || to_ev)) begin
      fr_d = F_HUNT;
    end else if (good_byte) begin
      xor_d = xor_q ^ uart_data;
      case (fr_q)
        F_HUNT: if (uart_data == SOF_BYTE) begin
          fr_d  = F_CMD;
          xor_d = 8'd0;
        end
        F_CMD:  begin wrb_d  = uart_data[7]; fr_d = F_ADDR; end
        F_ADDR: begin addr_d = uart_data;    fr_d = F_DH;   end
        F_DH:   begin dh_d   = uart_data;    fr_d = F_DL;   end
        F_DL:   begin dl_d   = uart_data;    fr_d = F_CHK;  end
        F_CHK: begin
          if (uart_data == xor_q) begin
            cv_d    = 1'b1;
            cwr_d   = wrb_q;
            caddr_d = addr_q;
            cwd_d   = {dh_q, dl_q};
            fr_d    = F_OUTPUT;
          end else begin
            chk_ev = 1'b1;
            fr_d   = F_HUNT;
          end
        end
        default: fr_d = F_HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_q    <= RD_IDLE;
      fr_q    <= F_HUNT;
      wcnt_q  <= 2'd0;
      tcnt_q  <= 17'd0;
      wrb_q   <= 1'b0;
      addr_q  <= 8'd0;
      dh_q    <= 8'd0;
      dl_q    <= 8'd0;
      xor_q   <= 8'd0;
      cv_q    <= 1'b0;
      cwr_q   <= 1'b0;
      caddr_q <= 8'd0;
      cwd_q   <= 16'd0;
      ovf_q   <= 1'b0;
      ech_q   <= 1'b0;
      eto_q   <= 1'b0;
      eln_q   <= 1'b0;
      ecnt_q  <= 8'd0;
    end else begin
      rd_q    <= rd_d;
      fr_q    <= fr_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      wrb_q   <= wrb_d;
      addr_q  <= addr_d;
      dh_q    <= dh_d;
      dl_q    <= dl_d;
      xor_q   <= xor_d;
      cv_q    <= cv_d;
      cwr_q   <= cwr_d;
      caddr_q <= caddr_d;
      cwd_q   <= cwd_d;
      ovf_q   <= uart_ovf;
      // Only the highest-priority error of a cycle is reported and counted.
      eln_q   <= line_ev;
      eto_q   <= to_ev & ~line_ev;
      ech_q   <= chk_ev;
      ecnt_q  <= (line_ev || to_ev || chk_ev) ? sat_inc(ecnt_q) : ecnt_q;
    end
  end

  assign uart_csn    = (rd_q != RD_STRB);
  assign uart_oen    = (rd_q != RD_STRB);
  assign cmd_valid   = cv_q;
  assign cmd_wr      = cwr_q;
  assign cmd_addr    = caddr_q;
  assign cmd_wdata   = cwd_q;
  assign err_chk     = ech_q;
  assign err_timeout = eto_q;
  assign err_line    = eln_q;
  assign err_cnt     = ecnt_q;

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Randomized bench for uart_cmd_deframer: a FIFO-based UART model feeds bytes and
// a frame-level reference model predicts the ordered stream of commands and errors.
module tb_uart_cmd_deframer;
  localparam int         RD_LAT = 2;
  localparam int         TO     = 100;
  localparam logic [7:0] SOF    = 8'hA5;
  localparam int K_CMD = 0, K_CHK = 1, K_TO = 2, K_LINE = 3;

  typedef struct {
    int          kind;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wd;
  } ev_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        uart_rxrdy, uart_csn, uart_oen, cmd_valid, cmd_wr;
  logic        cmd_ready = 1'b1;
  logic        uart_ovf = 1'b0;
  logic [7:0]  ud = 8'd0;
  logic        up = 1'b0, uf = 1'b0;
  logic [7:0]  cmd_addr, err_cnt;
  logic [15:0] cmd_wdata;
  logic        err_chk, err_timeout, err_line;

  always #5 CLK = ~CLK;

  uart_cmd_deframer #(.RD_LAT(RD_LAT), .TIMEOUT_CYC(TO), .SOF_BYTE(SOF)) dut (
    .CLK(CLK), .RESET(RESET), .uart_rxrdy(uart_rxrdy), .uart_data(ud),
    .uart_par_err(up), .uart_frm_err(uf), .uart_ovf(uart_ovf),
    .uart_csn(uart_csn), .uart_oen(uart_oen), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .err_chk(err_chk), .err_timeout(err_timeout),
    .err_line(err_line), .err_cnt(err_cnt));

  // UART receive FIFO model: a strobe pops the head onto DATA_OUT and the flags
  logic [9:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign uart_rxrdy = (wr_ptr != rd_ptr);
  always @(posedge CLK) begin
    if (!uart_csn && !uart_oen && wr_ptr != rd_ptr) begin
      {uf, up, ud} <= mem[rd_ptr % 4096];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  ev_t expq[$];
  int exp_cnt = 0;
  int mpos = 0;
  logic [7:0] mfb [1:4];
  int ready_mode = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input int k, input logic w, input logic [7:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = k; e.wr = w; e.addr = a; e.wd = d;
    expq.push_back(e);
  endfunction

  // Reference model: position within frame, checksum evaluated once all fields are in
  function automatic void model_byte(input logic [7:0] b, input logic p, input logic f);
    if (p || f) begin
      push_ev(K_LINE, 1'b0, 8'd0, 16'd0);
      mpos = 0;
    end else if (mpos == 0) begin
      if (b == SOF) mpos = 1;
    end else if (mpos < 5) begin
      mfb[mpos] = b;
      mpos++;
    end else begin
      if (b == (mfb[1] ^ mfb[2] ^ mfb[3] ^ mfb[4]))
        push_ev(K_CMD, mfb[1][7], mfb[2], {mfb[3], mfb[4]});
      else
        push_ev(K_CHK, 1'b0, 8'd0, 16'd0);
      mpos = 0;
    end
  endfunction

  function automatic void model_abort(input int k);
    if (k == K_LINE || mpos != 0) push_ev(k, 1'b0, 8'd0, 16'd0);
    mpos = 0;
  endfunction

  // Compare process: every cycle outside reset
  logic        pv_valid = 1'b0, pv_ready = 1'b0;
  logic [24:0] pv_fields = '0;
  always @(negedge CLK) begin
    logic [2:0] errs;
    logic [2:0] want;
    if (RESET) begin
      pv_valid = 1'b0;
      exp_cnt = 0;
      expq.delete();
    end else begin
      if (pv_valid && !pv_ready) begin
        check("hold_valid", {31'd0, cmd_valid}, 32'd1);
        check("hold_fields", {7'd0, cmd_wr, cmd_addr, cmd_wdata}, {7'd0, pv_fields});
      end
      if (cmd_valid) begin
        check("no_read_in_output", {30'd0, uart_csn, uart_oen}, 32'd3);
        if (expq.size() == 0 || expq[0].kind != K_CMD) begin
          check("unexpected_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        end else begin
          check("cmd_fields", {7'd0, cmd_wr, cmd_addr, cmd_wdata},
                {7'd0, expq[0].wr, expq[0].addr, expq[0].wd});
          if (cmd_ready) void'(expq.pop_front());
        end
      end
      errs = {err_line, err_timeout, err_chk};
      if (errs != 3'b000) begin
        check("err_onehot", {29'd0, errs & (errs - 3'd1)}, 32'd0);
        if (expq.size() == 0 || expq[0].kind == K_CMD) begin
          check("unexpected_err", {29'd0, errs}, 32'd0);
        end else begin
          want = (expq[0].kind == K_LINE) ? 3'b100 : (expq[0].kind == K_TO) ? 3'b010 : 3'b001;
          check("err_kind", {29'd0, errs}, {29'd0, want});
          void'(expq.pop_front());
        end
        exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
      end
      check("err_cnt", {24'd0, err_cnt}, exp_cnt);
      pv_valid  = cmd_valid;
      pv_ready  = cmd_ready;
      pv_fields = {cmd_wr, cmd_addr, cmd_wdata};
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      cmd_ready = (ready_mode == 1) ? 1'b1 :
                  (ready_mode == 0) ? 1'b0 : ($urandom_range(0, 9) < 7);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while (rd_ptr != wr_ptr && t < 5000) begin step(); t++; end
    if (t >= 5000) check("drain_bound", rd_ptr, wr_ptr);
    repeat (RD_LAT + 4) step();
  endtask

  task automatic wait_idle();
    int t = 0;
    drain();
    while (expq.size() != 0 && t < 3000) begin step(); t++; end
    if (expq.size() != 0) check("pending_events", expq.size(), 0);
  endtask

  task automatic push(input logic [7:0] b, input logic p, input logic f, input bit gap, input int gmax);
    if (gap) begin
      drain();
      model_abort(K_TO);
      repeat (TO + 20) step();
    end
    model_byte(b, p, f);
    mem[wr_ptr % 4096] = {f, p, b};
    wr_ptr = wr_ptr + 1;
    repeat ($urandom_range(0, gmax)) step();
  endtask

  task automatic push_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] flip, input int gmax);
    push(SOF, 1'b0, 1'b0, 1'b0, gmax);
    push(c, 1'b0, 1'b0, 1'b0, gmax);
    push(a, 1'b0, 1'b0, 1'b0, gmax);
    push(h, 1'b0, 1'b0, 1'b0, gmax);
    push(l, 1'b0, 1'b0, 1'b0, gmax);
    push(c ^ a ^ h ^ l ^ flip, 1'b0, 1'b0, 1'b0, gmax);
  endtask

  task automatic do_reset();
    step();
    RESET = 1'b1;
    step();
    wr_ptr = rd_ptr;
    mpos = 0;
    step();
    RESET = 1'b0;
  endtask

  initial begin
    ev_t e;
    int t;
    logic [7:0] c, a, h, l, x;
    int r, k;
    #1 RESET = 1'b1;
    #1;
    check("rst_csn_oen", {30'd0, uart_csn, uart_oen}, 32'd3);
    check("rst_cmd", {6'd0, cmd_valid, cmd_wr, cmd_addr, cmd_wdata}, 32'd0);
    check("rst_err", {21'd0, err_line, err_timeout, err_chk, err_cnt}, 32'd0);
    step(); step();
    RESET = 1'b0;
    step();

    // T1: single write frame
    push_frame(8'h81, 8'h10, 8'h12, 8'h34, 8'h00, 0);
    e = expq[expq.size() - 1];
    check("t1_model", {e.kind[6:0], e.wr, e.addr, e.wd}, {7'd0, 1'b1, 8'h10, 16'h1234});
    wait_idle();

    // T2: garbage then read frame
    push(8'h00, 1'b0, 1'b0, 1'b0, 0);
    push(8'hFF, 1'b0, 1'b0, 1'b0, 0);
    push(8'h5A, 1'b0, 1'b0, 1'b0, 0);
    push_frame(8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 0);
    e = expq[expq.size() - 1];
    check("t2_model", {e.kind[6:0], e.wr, e.addr, 16'd0}, {7'd0, 1'b0, 8'h20, 16'd0});
    wait_idle();
    check("t2_errcnt", {24'd0, err_cnt}, 32'd0);

    // T3: bad checksum, then good frame
    do_reset();
    push(SOF, 1'b0, 1'b0, 1'b0, 0);
    push(8'h81, 1'b0, 1'b0, 1'b0, 0);
    push(8'h10, 1'b0, 1'b0, 1'b0, 0);
    push(8'h12, 1'b0, 1'b0, 1'b0, 0);
    push(8'h34, 1'b0, 1'b0, 1'b0, 0);
    push(8'hB6, 1'b0, 1'b0, 1'b0, 0);
    check("t3_model", expq[expq.size() - 1].kind, K_CHK);
    push_frame(8'h02, 8'h33, 8'hBE, 8'hEF, 8'h00, 1);
    wait_idle();
    check("t3_errcnt", {24'd0, err_cnt}, 32'd1);

    // T4: backpressure with two frames queued
    ready_mode = 0;
    push_frame(8'h85, 8'h44, 8'hCA, 8'hFE, 8'h00, 0);
    push_frame(8'h06, 8'h55, 8'h00, 8'h01, 8'h00, 0);
    t = 0;
    while (!cmd_valid && t < 500) begin step(); t++; end
    check("t4_valid", {31'd0, cmd_valid}, 32'd1);
    repeat (50) step();
    check("t4_oen", {31'd0, uart_oen}, 32'd1);
    check("t4_addr", {24'd0, cmd_addr}, 32'h44);
    ready_mode = 1;
    wait_idle();

    // T5: inter-byte timeout
    do_reset();
    push(SOF, 1'b0, 1'b0, 1'b0, 0);
    push(8'h81, 1'b0, 1'b0, 1'b0, 0);
    push(8'h10, 1'b0, 1'b0, 1'b1, 0);
    wait_idle();
    check("t5_errcnt", {24'd0, err_cnt}, 32'd1);

    // Overflow rising edge aborts the frame in progress
    push(SOF, 1'b0, 1'b0, 1'b0, 0);
    push(8'h81, 1'b0, 1'b0, 1'b0, 0);
    drain();
    model_abort(K_LINE);
    uart_ovf = 1'b1;
    repeat (3) step();
    uart_ovf = 1'b0;
    push(8'h10, 1'b0, 1'b0, 1'b0, 0);
    push(8'h12, 1'b0, 1'b0, 1'b0, 0);
    push(8'h34, 1'b0, 1'b0, 1'b0, 0);
    push(8'hB7, 1'b0, 1'b0, 1'b0, 0);
    push_frame(8'h81, 8'h10, 8'h12, 8'h34, 8'h00, 0);
    wait_idle();
    check("ovf_errcnt", {24'd0, err_cnt}, 32'd2);

    // T6a: parity error on ADDR drops the frame
    push(SOF, 1'b0, 1'b0, 1'b0, 0);
    push(8'h81, 1'b0, 1'b0, 1'b0, 0);
    push(8'h10, 1'b1, 1'b0, 1'b0, 0);
    push(8'h12, 1'b0, 1'b0, 1'b0, 0);
    push(8'h34, 1'b0, 1'b0, 1'b0, 0);
    push(8'hB7, 1'b0, 1'b0, 1'b0, 0);
    push_frame(8'h03, 8'h77, 8'h12, 8'h21, 8'h00, 0);
    wait_idle();
    check("t6_errcnt", {24'd0, err_cnt}, 32'd3);

    // T6b: async reset while the reader waits on DATA_OUT
    push(SOF, 1'b0, 1'b0, 1'b0, 0);
    push(8'h81, 1'b0, 1'b0, 1'b0, 0);
    push(8'h10, 1'b0, 1'b0, 1'b0, 0);
    t = 0;
    while (uart_oen && t < 200) begin step(); t++; end
    check("t6_strobe_seen", {31'd0, uart_oen}, 32'd0);
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("t6_rst_csn_oen", {30'd0, uart_csn, uart_oen}, 32'd3);
    check("t6_rst_cmd", {6'd0, cmd_valid, cmd_wr, cmd_addr, cmd_wdata}, 32'd0);
    check("t6_rst_err", {21'd0, err_line, err_timeout, err_chk, err_cnt}, 32'd0);
    step();
    wr_ptr = rd_ptr;
    mpos = 0;
    step();
    RESET = 1'b0;
    repeat (30) step();
    check("t6_no_spurious", {31'd0, cmd_valid}, 32'd0);

    // Randomized frames, corruption and backpressure
    ready_mode = 2;
    for (int it = 0; it < 70; it++) begin
      r = $urandom_range(0, 99);
      c = 8'($urandom); a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
      if (r < 50) begin
        push_frame(c, a, h, l, 8'h00, 3);
      end else if (r < 65) begin
        x = 8'($urandom_range(1, 255));
        push_frame(c, a, h, l, x, 3);
      end else if (r < 78) begin
        repeat ($urandom_range(1, 4)) push(8'($urandom), 1'b0, 1'b0, 1'b0, 3);
      end else if (r < 90) begin
        k = $urandom_range(1, 5);
        push(SOF, 1'b0, 1'b0, 1'b0, 3);
        for (int i = 1; i <= 5; i++) begin
          x = 8'($urandom);
          if (i == k) push(x, r[0], ~r[0], 1'b0, 3);
          else push(x, 1'b0, 1'b0, 1'b0, 3);
        end
      end else begin
        push(SOF, 1'b0, 1'b0, 1'b0, 3);
        push(c, 1'b0, 1'b0, 1'b0, 3);
        push(a, 1'b0, 1'b0, 1'b1, 3);
        push(h, 1'b0, 1'b0, 1'b0, 3);
        push(l, 1'b0, 1'b0, 1'b0, 3);
      end
    end
    // Zero bytes guarantee the frame FSM is back in HUNT before idling
    repeat (6) push(8'h00, 1'b0, 1'b0, 1'b0, 0);
    wait_idle();

    // Error counter saturation
    ready_mode = 1;
    do_reset();
    for (int i = 0; i < 262; i++) push(8'($urandom), 1'b1, 1'b0, 1'b0, 0);
    wait_idle();
    check("sat_errcnt", {24'd0, err_cnt}, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
